// File: rtl/moore_pkg.sv
// Purpose: shared helpers for the Moore sequence detector (width math, limits).
// Latency: n/a (elaboration-time constants and constant functions only).
// Backpressure: n/a.
package moore_pkg;

  // Longest pattern the next-state builder is sized for.
  localparam int MAX_PAT_LEN = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // States S0..S_patLen need patLen+1 encodings.
  function automatic int stateWidth(input int patLen);
    return clog2(patLen + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// Purpose: N-bit register with synchronous active-high reset and load enable.
// Latency: 1 cycle from d to q on an enabled edge.
// Backpressure: none; en=0 holds the current value.
// Ports: clk (rising edge), rst (sync, high), en (load), d (next value), q (current value).
module dff_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/moore_seq_detector.sv
// Purpose: Moore FSM detecting PATTERN (MSB first) in a serial bit stream, with a saturating hit counter.
// Latency: outputZ rises the cycle after the edge that accepts the final pattern bit.
// Backpressure: none; inputEn=0 freezes state/count/err (except recovery from an illegal state).
// Ports: inputClk, inputR (sync reset, high), inputEn (sample valid), inputX (data bit),
//        outputZ (detect), outputState (state index), outputCount (hits), outputErr (sticky illegal-state).
module moore_seq_detector
  import moore_pkg::*;
#(
  parameter int               PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8,
  localparam int              STATE_W = stateWidth(PAT_LEN)
) (
  input  logic               inputClk,
  input  logic               inputR,
  input  logic               inputEn,
  input  logic               inputX,
  output logic               outputZ,
  output logic [STATE_W-1:0] outputState,
  output logic [CNT_W-1:0]   outputCount,
  output logic               outputErr
);

  // Next state from Sk on bit x: longest prefix of PATTERN that is a suffix of
  // (first k pattern bits, x). Evaluated only at elaboration.
  function automatic int nextOf(input int k, input logic x);
    logic [MAX_PAT_LEN:0] seq;
    int                   len;
    int                   best;
    logic                 ok;
    seq = '0;
    for (int i = 0; i < PAT_LEN; i++) begin
      if (i < k) seq[i] = PATTERN[PAT_LEN-1-i];
    end
    seq[k] = x;
    len  = k + 1;
    best = 0;
    for (int m = 1; m <= PAT_LEN; m++) begin
      ok = (m <= len);
      for (int j = 0; j < PAT_LEN; j++) begin
        if (ok && (j < m)) begin
          if (seq[len-m+j] != PATTERN[PAT_LEN-1-j]) ok = 1'b0;
        end
      end
      if (ok) best = m;
    end
    return best;
  endfunction

  logic [STATE_W-1:0] nextTbl0 [PAT_LEN+1];
  logic [STATE_W-1:0] nextTbl1 [PAT_LEN+1];

  for (genvar k = 0; k <= PAT_LEN; k++) begin : gTbl
    // Without overlap, a completed match restarts as if from S0.
    localparam int SRC = ((k == PAT_LEN) && !OVERLAP) ? 0 : k;
    assign nextTbl0[k] = STATE_W'(nextOf(SRC, 1'b0));
    assign nextTbl1[k] = STATE_W'(nextOf(SRC, 1'b1));
  end

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] stateNext;
  logic [CNT_W-1:0]   count;
  logic               illegal;
  logic               enterDetect;

  assign illegal = (state > STATE_W'(PAT_LEN));

  // An out-of-range state matches no table row, so stateNext falls back to S0.
  always_comb begin
    stateNext = '0;
    for (int k = 0; k <= PAT_LEN; k++) begin
      if (state == STATE_W'(k)) stateNext = inputX ? nextTbl1[k] : nextTbl0[k];
    end
  end

  assign enterDetect = inputEn && !illegal && (stateNext == STATE_W'(PAT_LEN));

  // Illegal-state recovery ignores inputEn.
  dff_stage #(.W(STATE_W)) uStateReg (
    .clk (inputClk),
    .rst (inputR),
    .en  (inputEn | illegal),
    .d   (stateNext),
    .q   (state)
  );

  dff_stage #(.W(CNT_W)) uCountReg (
    .clk (inputClk),
    .rst (inputR),
    .en  (enterDetect && (count != {CNT_W{1'b1}})),
    .d   (count + CNT_W'(1)),
    .q   (count)
  );

  // Sticky: loads 1 on any illegal-state edge, cleared only by reset.
  dff_stage #(.W(1)) uErrReg (
    .clk (inputClk),
    .rst (inputR),
    .en  (illegal),
    .d   (1'b1),
    .q   (outputErr)
  );

  assign outputZ     = (state == STATE_W'(PAT_LEN));
  assign outputState = state;
  assign outputCount = count;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Purpose: scoreboard bench for moore_seq_detector; three instances share one stimulus stream.
// Latency: expectations are queued at drive time and popped one cycle later by the monitor.
// Backpressure: n/a.
module tb_moore_seq_detector;

  localparam int         PAT_LEN = 4;
  localparam logic [3:0] PAT     = 4'b1011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic inputR  = 1'b1;
  logic inputEn = 1'b0;
  logic inputX  = 1'b0;

  logic       zA, zB, zC, errA, errB, errC;
  logic [2:0] stA, stB, stC;
  logic [7:0] cntA, cntB;
  logic [1:0] cntC;

  // A: overlapping, 8-bit count.  B: non-overlapping.  C: overlapping, 2-bit count.
  moore_seq_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(8)) dutA (
    .inputClk(clk), .inputR(inputR), .inputEn(inputEn), .inputX(inputX),
    .outputZ(zA), .outputState(stA), .outputCount(cntA), .outputErr(errA));
  moore_seq_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PAT), .OVERLAP(1'b0), .CNT_W(8)) dutB (
    .inputClk(clk), .inputR(inputR), .inputEn(inputEn), .inputX(inputX),
    .outputZ(zB), .outputState(stB), .outputCount(cntB), .outputErr(errB));
  moore_seq_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(2)) dutC (
    .inputClk(clk), .inputR(inputR), .inputEn(inputEn), .inputX(inputX),
    .outputZ(zC), .outputState(stC), .outputCount(cntC), .outputErr(errC));

  typedef struct packed {
    logic [2:0] st;
    logic       z;
    logic [7:0] cnt;
    logic       err;
  } obs_t;
  typedef obs_t [2:0] trio_t;

  trio_t expQ[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: a sliding window of the last PAT_LEN accepted bits.
  int hb[3];
  int hl[3];
  int mst[3];
  int mcnt[3];
  int pend[3];
  int merr[3];
  int cntMax[3] = '{255, 255, 3};
  int ovl[3]    = '{1, 0, 1};

  function automatic int matchLen(input int bits, input int len);
    for (int k = PAT_LEN; k >= 1; k--) begin
      if (len >= k && (bits & ((1 << k) - 1)) == (int'(PAT) >> (PAT_LEN - k))) return k;
    end
    return 0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      hb[i] = 0; hl[i] = 0; mst[i] = 0; mcnt[i] = 0; pend[i] = 0; merr[i] = 0;
    end
  endtask

  task automatic modelBit(input int x);
    for (int i = 0; i < 3; i++) begin
      if (pend[i] != 0) begin
        hb[i] = 0; hl[i] = 0; pend[i] = 0;
      end
      hb[i] = ((hb[i] << 1) | x) & ((1 << PAT_LEN) - 1);
      if (hl[i] < PAT_LEN) hl[i]++;
      mst[i] = matchLen(hb[i], hl[i]);
      if (mst[i] == PAT_LEN) begin
        if (mcnt[i] < cntMax[i]) mcnt[i]++;
        if (ovl[i] == 0) pend[i] = 1;
      end
    end
  endtask

  function automatic trio_t expNow();
    trio_t t;
    for (int i = 0; i < 3; i++) begin
      t[i].st  = 3'(mst[i]);
      t[i].z   = (mst[i] == PAT_LEN);
      t[i].cnt = 8'(mcnt[i]);
      t[i].err = (merr[i] != 0);
    end
    return t;
  endfunction

  task automatic step(input logic r, input logic en, input logic x);
    @(negedge clk);
    inputR  = r;
    inputEn = en;
    inputX  = x;
    if (r) modelReset();
    else if (en) modelBit(int'(x));
    expQ.push_back(expNow());
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmpObs(input int idx, input obs_t e, input obs_t a);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL sb_dut%0d t=%0t got st=%0d z=%0d cnt=%0d err=%0d want st=%0d z=%0d cnt=%0d err=%0d",
               idx, $time, a.st, a.z, a.cnt, a.err, e.st, e.z, e.cnt, e.err);
    end
  endtask

  // Monitor: one observation per clock, matched against the oldest queued expectation.
  initial begin
    trio_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        cmpObs(0, e[0], {stA, zA, cntA, errA});
        cmpObs(1, e[1], {stB, zB, cntB, errB});
        cmpObs(2, e[2], {stC, zC, 6'b0, cntC, errC});
      end
    end
  end

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int s1[7];
    int gapBits[4];
    s1      = '{1, 0, 1, 1, 0, 1, 1};
    gapBits = '{1, 0, 1, 1};

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    settle();
    chk("reset_state", int'(stA), 0);
    chk("reset_z", int'(zA), 0);
    chk("reset_cnt", int'(cntA), 0);
    chk("reset_err", int'(errA), 0);

    // Overlap vs non-overlap on 1011011.
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'(s1[i]));
      if (i == 3) begin
        settle();
        chk("zA_after_bit4", int'(zA), 1);
        chk("zB_after_bit4", int'(zB), 1);
      end
      if (i == 4) begin
        settle();
        chk("stA_after_bit5", int'(stA), 2);
      end
    end
    settle();
    chk("cntA_overlap", int'(cntA), 2);
    chk("zA_after_bit7", int'(zA), 1);
    chk("stB_final", int'(stB), 1);
    chk("cntB_nonoverlap", int'(cntB), 1);

    // Enable gap between bits 2 and 3, then idle after detection.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'(gapBits[i]));
      if (i == 1) begin
        for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        settle();
        chk("stA_gap_hold", int'(stA), 2);
      end
    end
    for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    settle();
    chk("zA_hold_idle", int'(zA), 1);

    // Reset mid-pattern discards history.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    settle();
    chk("stA_at_S3", int'(stA), 3);
    step(1'b1, 1'b1, 1'b1);
    settle();
    chk("stA_mid_reset", int'(stA), 0);
    chk("cntA_mid_reset", int'(cntA), 0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    settle();
    chk("cntA_no_stale_match", int'(cntA), 0);

    // Saturation with a 2-bit counter.
    step(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'(gapBits[i]));
      settle();
      chk("cntC_sat", int'(cntC), (r < 3) ? r + 1 : 3);
    end
    chk("cntA_five", int'(cntA), 5);

    // Illegal state on dutA: forced to 7 across one edge with inputEn low.
    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    inputEn = 1'b0;
    force dutA.state = 3'd7;
    @(negedge clk);
    release dutA.state;
    @(negedge clk);
    chk("illegal_recover_state", int'(stA), 0);
    chk("illegal_err_set", int'(errA), 1);
    chk("illegal_cnt_hold", int'(cntA), 5);
    chk("other_err_clear", int'(errB), 0);
    hb[0] = 0; hl[0] = 0; pend[0] = 0; mst[0] = 0; merr[0] = 1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    settle();
    chk("err_sticky", int'(errA), 1);
    step(1'b1, 1'b0, 1'b0);
    settle();
    chk("err_cleared_by_reset", int'(errA), 0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    chk("queue_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moore_seq_detector.md
MOORE_SEQ_DETECTOR -- requirements
Module: moore_seq_detector

Interface
REQ-001 Parameter PAT_LEN, default 4: pattern length in bits; legal range 2..8.
REQ-002 Parameter PATTERN, default 4'b1011: PAT_LEN-bit pattern, MSB received first.
REQ-003 Parameter OVERLAP, default 1: 1 allows overlapping detections, 0 restarts matching after each detection.
REQ-004 Parameter CNT_W, default 8: width of the detection counter.
REQ-005 Derived STATE_W = clog2(PAT_LEN+1).
REQ-006 inputClk  in  1  single clock; all state updates on the rising edge.
REQ-007 inputR  in  1  reset; synchronous, active-high.
REQ-008 inputEn  in  1  sample-valid; inputX is consumed only on edges where inputEn=1.
REQ-009 inputX  in  1  serial data bit.
REQ-010 outputZ  out  1  Moore detect flag.
REQ-011 outputState  out  STATE_W  current state index, 0..PAT_LEN.
REQ-012 outputCount  out  CNT_W  saturating detection count.
REQ-013 outputErr  out  1  sticky illegal-state flag.

Function
REQ-014 The design SHALL have PAT_LEN+1 states S0..S_PAT_LEN; Sk means the longest suffix of accepted bits that equals a prefix of PATTERN has length k.
REQ-015 With inputEn=1, next state from Sk (k<PAT_LEN) on bit x SHALL be the length of the longest prefix of PATTERN that is a suffix of (PATTERN[first k bits], x).
REQ-016 From S_PAT_LEN with OVERLAP=1, next state SHALL be computed as in REQ-015 using all PAT_LEN pattern bits plus x.
REQ-017 From S_PAT_LEN with OVERLAP=0, next state SHALL equal the transition from S0 on x.
REQ-018 With inputEn=0, state, outputCount and outputErr SHALL hold.
REQ-019 outputZ SHALL be 1 iff state = S_PAT_LEN; it depends on registered state only, never on inputX or inputEn.
REQ-020 outputZ SHALL rise the cycle after the edge that accepted the final pattern bit and stay high until the next accepted bit moves the state.
REQ-021 outputCount SHALL increment by 1 on each edge on which the state enters S_PAT_LEN; at 2^CNT_W-1 it SHALL hold.
REQ-022 Any state value > PAT_LEN SHALL transition to S0 on the next edge regardless of inputEn, and SHALL set outputErr on that edge.
REQ-023 outputErr SHALL remain 1 until reset; the illegal cycle SHALL NOT increment outputCount.
REQ-024 outputState SHALL equal the state register directly.

Reset
REQ-025 On an edge with inputR=1: state=S0, outputZ=0, outputCount=0, outputErr=0.
REQ-026 Reset SHALL take priority over inputEn, illegal-state recovery and counting on the same edge.
REQ-027 Reset mid-pattern SHALL discard all partial-match history; matching restarts from S0 on the first accepted bit after inputR falls.

Structure
REQ-028 Shared package moore_pkg SHALL hold the clog2 function and the state-width computation.
REQ-029 Next-state table SHALL be computed at elaboration from PATTERN/OVERLAP, with no runtime pattern memory.
REQ-030 The state and counter registers SHALL use one sub-module, dff_stage: an N-bit register with synchronous active-high reset and enable, instantiated per register.

Verification
REQ-031 PAT_LEN=4, PATTERN=1011, OVERLAP=1, bits 1,0,1,1,0,1,1 (inputEn=1) -> outputZ high after bits 4 and 7; outputCount=2; state after bit 5 = S2.
REQ-032 Same stream with OVERLAP=0 -> outputZ high only after bit 4; final state S1; outputCount=1.
REQ-033 Stream 1,0,1,1 with inputEn=0 for 3 cycles between bits 2 and 3 -> state holds at S2 during gap; detection after bit 4; outputZ stays 1 while inputEn=0 follows.
REQ-034 Reach S3, assert inputR one cycle with inputEn=1, inputX=1 -> state S0, outputZ=0, outputCount=0; then 0,1,1 gives no detection.
REQ-035 CNT_W=2, stream 1011 repeated 5 times -> outputCount reads 1,2,3,3,3.
REQ-036 Force state register to 7 (PAT_LEN=4) with inputEn=0 -> next edge state S0, outputErr=1, outputCount unchanged; outputErr stays 1 until inputR.
